// File: rtl/ifetch_queue_if.sv
// Fetch-queue interface: groups the instruction-memory request/ack channel,
// the redirect input and the head-of-queue output toward the IF/ID register.
//   imem_req/imem_addr   : request and word address [31:2] (queue -> memory)
//   imem_ack/imem_rdata  : completion and instruction word (memory -> queue)
//   redirect/redirect_pc : flush and restart at a new word PC (pipeline -> queue)
//   deq                  : consumer takes the head entry (pipeline -> queue)
//   out_valid/out_pc/out_instr : head entry (queue -> pipeline)
// Modport master is the fetch queue; modport slave is its environment.
interface ifetch_queue_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic        deq;
    logic        out_valid;
    logic [29:0] out_pc;
    logic [31:0] out_instr;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        input  deq,
        output out_valid,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        output deq,
        input  out_valid,
        input  out_pc,
        input  out_instr
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue sitting in front of the IF stage.
// Issues word requests to a variable-latency instruction memory, buffers the
// returned words with their PCs in a DEPTH-entry FIFO and presents the head
// entry to the IF/ID register. A redirect flushes the FIFO and discards any
// return still in flight for the abandoned path.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-low reset
//   bus : ifetch_queue_if.master (memory channel, redirect, deq, head entry)
// Parameters:
//   DEPTH    : FIFO entries, power of two, at least 2
//   RESET_PC : word PC fetched first after reset
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master bus
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned PC_W    = 30;
    localparam int unsigned INSTR_W = 32;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // IDLE: no request outstanding; WAIT: live request; DROP: request whose
    // data belongs to a path that has since been redirected away from.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    state_t             state_q,    state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    req_addr_q, req_addr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;

    logic               wr_en;
    logic               pop;
    logic               room;
    logic               req_active;

    entry_t             fifo_mem [DEPTH];
    entry_t             head;

    // A request is on the bus in both WAIT and DROP; ack is only meaningful then.
    assign req_active = (state_q == WAIT) || (state_q == DROP);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Next-state, FIFO bookkeeping and request sequencing.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        wr_en      = 1'b0;
        pop        = 1'b0;
        room       = 1'b0;

        if (bus.redirect) begin
            // Flush wins over any same-cycle pop or write.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            unique case (state_q)
                IDLE: begin
                    fetch_pc_d = bus.redirect_pc;
                    req_addr_d = bus.redirect_pc;
                    state_d    = WAIT;
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        // Old word discarded; new request goes out immediately.
                        req_addr_d = bus.redirect_pc;
                        fetch_pc_d = bus.redirect_pc + PC_W'(1);
                    end else begin
                        // Address must stay stable until the old request acks.
                        fetch_pc_d = bus.redirect_pc;
                        state_d    = DROP;
                    end
                end
                DROP: begin
                    fetch_pc_d = bus.redirect_pc;
                    if (bus.imem_ack) begin
                        req_addr_d = bus.redirect_pc;
                        state_d    = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            wr_en   = (state_q == WAIT) && bus.imem_ack;
            pop     = bus.deq && (count_q != '0);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
            // Room is judged on the post-edge occupancy so a request is only
            // ever outstanding with a slot already reserved for its data.
            room    = count_d < DEPTH_CNT;
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (room) begin
                        req_addr_d = fetch_pc_q;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        fetch_pc_d = req_addr_q + PC_W'(1);
                        if (room) begin
                            // Back-to-back issue keeps zero-wait memory at one word per cycle.
                            req_addr_d = req_addr_q + PC_W'(1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        req_addr_d = fetch_pc_q;
                        state_d    = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            fifo_mem[wr_ptr_q].pc    <= req_addr_q;
            fifo_mem[wr_ptr_q].instr <= bus.imem_rdata;
        end
    end

    assign head = fifo_mem[rd_ptr_q];

    assign bus.imem_req  = req_active;
    assign bus.imem_addr = req_addr_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a latency-programmable memory model, a scoreboard of
// expected head entries, and directed scenarios followed by a random phase.
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [29:0] RESET_PC = 30'h0000_0C00;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic rst;

    ifetch_queue_if bus ();

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned tests;
    int unsigned fails;

    exp_t        sb[$];
    logic [29:0] exp_addr;
    bit          stale;
    int unsigned lat;
    int unsigned wait_cnt;
    bit          prev_pending;
    logic [29:0] prev_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[13:0], a[29:12]} ^ 32'hC3A5_96E1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory response, check outputs against the model,
    // advance the model for the coming edge, then wait to the next falling edge.
    task automatic cycle();
        bit xfer;
        if (lat == 0) bus.imem_ack = 1'b1;
        else          bus.imem_ack = (bus.imem_req === 1'b1) && (wait_cnt >= lat);
        bus.imem_rdata = mem_word(bus.imem_addr);

        if (rst === 1'b1) begin
            check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
            if (sb.size() != 0 && bus.out_valid === 1'b1) begin
                check("out_pc", 64'(bus.out_pc), 64'(sb[0].pc));
                check("out_instr", 64'(bus.out_instr), 64'(sb[0].instr));
            end
            if (bus.imem_req === 1'b1 && !stale)
                check("req_addr", 64'(bus.imem_addr), 64'(exp_addr));
            if (sb.size() == DEPTH)
                check("req_when_full", 64'(bus.imem_req), 64'd0);
            if (prev_pending) begin
                check("req_held", 64'(bus.imem_req), 64'd1);
                check("addr_held", 64'(bus.imem_addr), 64'(prev_addr));
            end
        end

        xfer = (bus.imem_req === 1'b1) && (bus.imem_ack === 1'b1);
        if (rst !== 1'b1) begin
            sb.delete();
            stale        = 1'b0;
            exp_addr     = RESET_PC;
            wait_cnt     = 0;
            prev_pending = 1'b0;
        end else begin
            prev_pending = (bus.imem_req === 1'b1) && !xfer;
            prev_addr    = bus.imem_addr;
            if (bus.imem_req === 1'b1) wait_cnt = xfer ? 0 : wait_cnt + 1;
            if (bus.redirect) begin
                sb.delete();
                if (prev_pending) stale = 1'b1;
                else if (xfer)    stale = 1'b0;
                exp_addr = bus.redirect_pc;
            end else begin
                if (bus.deq && sb.size() != 0) void'(sb.pop_front());
                if (xfer) begin
                    if (stale) stale = 1'b0;
                    else begin
                        sb.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
                        exp_addr = exp_addr + 30'd1;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;
        stale = 1'b0;
        lat = 0;
        wait_cnt = 0;
        prev_pending = 1'b0;
        prev_addr = '0;
        exp_addr = RESET_PC;
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.deq = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_req", 64'(bus.imem_req), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        cycle();

        // 1: zero-wait memory, continuous dequeue
        rst = 1'b1; bus.deq = 1'b1; lat = 0;
        cycle();
        check("t1_req", 64'(bus.imem_req), 64'd1);
        check("t1_addr", 64'(bus.imem_addr), 64'h0C00);
        check("t1_valid0", 64'(bus.out_valid), 64'd0);
        cycle();
        check("t1_pc0", 64'(bus.out_pc), 64'h0C00);
        check("t1_instr0", 64'(bus.out_instr), 64'(mem_word(30'h0C00)));
        cycle();
        check("t1_pc1", 64'(bus.out_pc), 64'h0C01);
        cycle();
        check("t1_pc2", 64'(bus.out_pc), 64'h0C02);
        check("t1_instr2", 64'(bus.out_instr), 64'(mem_word(30'h0C02)));
        repeat (4) cycle();

        // 2: fill without dequeue, then a single pop
        rst = 1'b0; cycle();
        rst = 1'b1; bus.deq = 1'b0;
        repeat (4) cycle();
        check("t2_req_before_full", 64'(bus.imem_req), 64'd1);
        cycle();
        check("t2_req_full", 64'(bus.imem_req), 64'd0);
        check("t2_head", 64'(bus.out_pc), 64'h0C00);
        cycle();
        check("t2_req_idle", 64'(bus.imem_req), 64'd0);
        bus.deq = 1'b1; cycle(); bus.deq = 1'b0;
        check("t2_pc_after_pop", 64'(bus.out_pc), 64'h0C01);
        check("t2_reissue", 64'(bus.imem_req), 64'd1);
        check("t2_reissue_addr", 64'(bus.imem_addr), 64'h0C04);
        cycle();
        check("t2_full_again", 64'(bus.imem_req), 64'd0);

        // 3: redirect while a slow request is outstanding
        lat = 3;
        bus.deq = 1'b1; cycle(); bus.deq = 1'b0;
        check("t3_issue_addr", 64'(bus.imem_addr), 64'h0C05);
        cycle();
        bus.redirect = 1'b1; bus.redirect_pc = 30'h0100;
        cycle();
        bus.redirect = 1'b0;
        check("t3_valid_after_redir", 64'(bus.out_valid), 64'd0);
        check("t3_addr_held", 64'(bus.imem_addr), 64'h0C05);
        cycle();
        check("t3_addr_held2", 64'(bus.imem_addr), 64'h0C05);
        cycle();
        check("t3_new_req", 64'(bus.imem_req), 64'd1);
        check("t3_new_addr", 64'(bus.imem_addr), 64'h0100);
        check("t3_still_empty", 64'(bus.out_valid), 64'd0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 12) begin cycle(); n++; end
        check("t3_fill_timeout", 64'(bus.out_valid), 64'd1);
        check("t3_first_pc", 64'(bus.out_pc), 64'h0100);

        // 4: redirect in the same cycle as ack
        n = 0;
        while (!(bus.imem_req === 1'b1 && wait_cnt >= lat) && n < 12) begin cycle(); n++; end
        check("t4_ack_reached", 64'(bus.imem_req), 64'd1);
        bus.redirect = 1'b1; bus.redirect_pc = 30'h0200;
        cycle();
        bus.redirect = 1'b0;
        check("t4_req", 64'(bus.imem_req), 64'd1);
        check("t4_addr", 64'(bus.imem_addr), 64'h0200);
        check("t4_flushed", 64'(bus.out_valid), 64'd0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 12) begin cycle(); n++; end
        check("t4_pc", 64'(bus.out_pc), 64'h0200);
        check("t4_next_addr", 64'(bus.imem_addr), 64'h0201);

        // 5: full FIFO, deq and redirect together; redirect target at the wrap point
        lat = 0;
        n = 0;
        while (bus.imem_req !== 1'b0 && n < 12) begin cycle(); n++; end
        check("t5_full_head", 64'(bus.out_pc), 64'h0200);
        bus.deq = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 30'h3FFF_FFFF;
        cycle();
        bus.deq = 1'b0; bus.redirect = 1'b0;
        check("t5_valid", 64'(bus.out_valid), 64'd0);
        check("t5_addr", 64'(bus.imem_addr), 64'h3FFF_FFFF);
        cycle();
        check("t5_pc", 64'(bus.out_pc), 64'h3FFF_FFFF);
        check("t5_wrap_addr", 64'(bus.imem_addr), 64'h0);

        // 6: reset in the middle of a request
        lat = 3;
        cycle();
        rst = 1'b0; cycle();
        check("t6_req", 64'(bus.imem_req), 64'd0);
        check("t6_valid", 64'(bus.out_valid), 64'd0);
        rst = 1'b1; lat = 0;
        cycle();
        check("t6_addr", 64'(bus.imem_addr), 64'h0C00);
        check("t6_empty", 64'(bus.out_valid), 64'd0);
        cycle();
        check("t6_pc", 64'(bus.out_pc), 64'h0C00);
        check("t6_instr", 64'(bus.out_instr), 64'(mem_word(30'h0C00)));

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            if ((i % 16) == 0) lat = $urandom_range(0, 2);
            bus.deq = 1'($urandom_range(0, 1));
            bus.redirect = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
            cycle();
        end
        bus.redirect = 1'b0;
        bus.deq = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipeline's IF stage.
- Issues word requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers the returned words with their PCs in a small FIFO, and presents the head entry to the IF/ID register.
- Handles control-flow redirects (taken branch, jump) by flushing the queue and discarding any in-flight return.

Parameters:
DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
RESET_PC, 30'h0000_0C00, word PC (bits [31:2]) fetched first after reset (byte address 0x0000_3000).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-low reset (rst==0 resets on the edge).
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  30  word address [31:2] of the current request.
imem_ack  in  1  memory completes the request this cycle.
imem_rdata  in  32  instruction word; valid when imem_ack=1.
redirect  in  1  flush and restart fetch at redirect_pc (from branch/jump resolution).
redirect_pc  in  30  new word PC [31:2].
deq  in  1  consumer takes the head entry (IF/ID write enable).
out_valid  out  1  head entry valid.
out_pc  out  30  PC [31:2] of the head entry.
out_instr  out  32  instruction word of the head entry.

Behaviour:
- Reset (rst==0 at the edge):
  - state=IDLE, count=0, rd_ptr=wr_ptr=0, fetch_pc=RESET_PC, req_addr=RESET_PC.
  - imem_req=0, out_valid=0; out_pc/out_instr are don't-care while out_valid=0.
  - Any outstanding request is abandoned; the memory side is reset on the same rst.
- Registers:
  - fetch_pc: next PC to request.
  - req_addr: drives imem_addr and is latched when a request issues.
  - count: log2(DEPTH)+1 bits.
  - Pointers: log2(DEPTH) bits, wrapping naturally.
- imem_req is 1 exactly in states WAIT and DROP.
- Handshake:
  - While imem_req=1, imem_addr must not change; the request cannot be withdrawn before ack.
  - The transfer completes in any cycle with imem_req=1 and imem_ack=1.
  - imem_ack is ignored when imem_req=0.
- "room" means count_next < DEPTH, where count_next accounts for the same-cycle write and pop.
- FSM, with redirect taking priority over every other event:
  - IDLE, redirect: fetch_pc<=redirect_pc, req_addr<=redirect_pc, go to WAIT.
  - IDLE, no redirect, room: req_addr<=fetch_pc, go to WAIT.
  - IDLE, otherwise: stay IDLE.
  - WAIT, redirect with ack: discard rdata; req_addr<=redirect_pc, fetch_pc<=redirect_pc+1, stay WAIT.
  - WAIT, redirect without ack: fetch_pc<=redirect_pc, go to DROP.
  - WAIT, ack, no redirect: write {req_addr, imem_rdata} at wr_ptr and set fetch_pc<=req_addr+1. If room remains after the write, req_addr<=req_addr+1 and stay WAIT; otherwise go to IDLE.
  - DROP, redirect: fetch_pc<=redirect_pc, stay DROP.
  - DROP, ack: discard rdata; req_addr<=fetch_pc (or redirect_pc if redirect is also asserted), go to WAIT.
- Zero-wait memory (ack tied high) sustains one instruction per cycle with imem_req held continuously high.
- FIFO:
  - out_valid = (count != 0); out_pc/out_instr are read combinationally from the entry at rd_ptr.
  - No bypass: a word acked in cycle n is visible at the output no earlier than cycle n+1.
  - deq while out_valid=1 pops (rd_ptr+1, count-1); deq while out_valid=0 is ignored.
  - Write and pop in the same cycle leave count unchanged.
  - A full FIFO never receives a write: no request is ever outstanding without a free slot.
- Redirect flushes the FIFO in the same edge (count<=0, rd_ptr<=wr_ptr<=0) and overrides a same-cycle deq or ack write.
  - out_valid=0 in the cycle after a redirect.
- PC arithmetic is 30-bit, wrapping from 30'h3FFF_FFFF to 0.

Test Plan:
1. Reset released, imem_ack=1 every cycle, deq=1 every cycle: imem_req rises 1 cycle after release with imem_addr=0x0C00. out_valid=1 the next cycle with out_pc=0x0C00, then 0x0C01, 0x0C02 on consecutive cycles, and out_instr matches the rdata returned for each address.
2. deq=0, ack=1: entries 0x0C00–0x0C03 fill the queue and imem_req drops the cycle after the 4th ack while out_pc holds 0x0C00. A single deq pulse gives out_pc=0x0C01 and re-issues imem_req with addr 0x0C04 on the next cycle.
3. Ack delayed 3 cycles; redirect=1 with redirect_pc=0x0100 one cycle after issue: imem_addr holds the old address until ack and the acked data is never enqueued. The next request carries addr 0x0100, and out_valid=0 from the cycle after the redirect.
4. redirect with redirect_pc=0x0200 in the same cycle as ack: the returned word is discarded, the next cycle shows imem_req=1 with addr 0x0200, and the following fetch is 0x0201.
5. Full FIFO with deq=1 and redirect=1 in the same cycle: count=0 and out_valid=0 next cycle; the first new entry has out_pc=redirect_pc.
6. rst=0 while in WAIT mid-request: next cycle imem_req=0 and out_valid=0. After release, the first request uses addr 0x0C00 and later acks for the old request are ignored.
